// File: rtl/alu_issue_control.sv
// alu_issue_control
//   Registered execute-stage op decoder and multiplier issue scheduler.
//   Decodes cu_alu_op/funct7/funct3 into an ALU op with one cycle of latency,
//   launches the multi-cycle multiplier, tracks the single in-flight mul and
//   stalls upstream on structural, WAW and writeback-port hazards.
//
//   Ports:
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     in_valid/in_ready instruction handshake from decode (in_ready is combinational)
//     in_funct7/3, in_cu_alu_op, in_rd   instruction fields and destination tag
//     out_valid, out_alu_op, out_set_nop, out_illegal, out_is_branch, out_rd
//                       registered decoded op, valid for one cycle per accept
//     mul_start         one-cycle pulse aligned with a mul's out_valid
//     mul_done_valid    one-cycle pulse MUL_LATENCY cycles after mul_start
//     mul_done_rd       destination tag of the completing mul
//     busy              a mul is in flight
module alu_issue_control #(
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned RD_WIDTH    = 5,
    parameter int unsigned OVERLAP     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          in_funct7,
    input  logic [2:0]          in_funct3,
    input  logic [1:0]          in_cu_alu_op,
    input  logic [RD_WIDTH-1:0] in_rd,
    output logic                out_valid,
    output logic [1:0]          out_alu_op,
    output logic                out_set_nop,
    output logic                out_illegal,
    output logic                out_is_branch,
    output logic [RD_WIDTH-1:0] out_rd,
    output logic                mul_start,
    output logic                mul_done_valid,
    output logic [RD_WIDTH-1:0] mul_done_rd,
    output logic                busy
);

    typedef enum logic {IDLE, MUL_WAIT} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic [RD_WIDTH-1:0] pend_rd, pend_rd_nxt;
    logic                done_nxt;

    logic [1:0]          dec_op;
    logic                dec_nop, dec_ill, dec_br, dec_mul;
    logic                ready_c, accept;

    // Instruction decode
    always_comb begin
        dec_op  = 2'b00;
        dec_nop = 1'b0;
        dec_ill = 1'b0;
        dec_br  = 1'b0;
        dec_mul = 1'b0;
        case (in_cu_alu_op)
            2'b10: begin
                if (in_funct3 == 3'b000 && in_funct7 == 7'b0000000) begin
                    dec_op = 2'b00;
                end else if (in_funct3 == 3'b000 && in_funct7 == 7'b0100000) begin
                    dec_op = 2'b01;
                end else if (in_funct3 == 3'b000 && in_funct7 == 7'b0000001) begin
                    dec_op  = 2'b10;
                    dec_mul = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                    dec_nop = 1'b1;
                end
            end
            2'b01: begin
                dec_op = 2'b01;
                dec_br = 1'b1;
            end
            2'b11:   dec_nop = 1'b1;
            default: dec_op  = 2'b00;
        endcase
    end

    // Issue hazards. With a mul in flight, counter == 1 means an op accepted
    // now would reach writeback in the same cycle as the mul result.
    always_comb begin
        ready_c = 1'b1;
        if (state == MUL_WAIT) begin
            if (OVERLAP == 0) begin
                ready_c = 1'b0;
            end else if (dec_mul) begin
                ready_c = 1'b0;
            end else if (in_rd != '0 && in_rd == pend_rd) begin
                ready_c = 1'b0;
            end else if (cnt == 4'd1) begin
                ready_c = 1'b0;
            end
        end
    end

    // Reset forces in_ready low along with every registered output.
    assign in_ready = rst_n & ready_c;
    assign accept   = in_valid & in_ready;

    // FSM next state
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_rd_nxt = pend_rd;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && dec_mul) begin
                    state_nxt   = MUL_WAIT;
                    cnt_nxt     = 4'(MUL_LATENCY);
                    pend_rd_nxt = in_rd;
                end
            end
            MUL_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            pend_rd        <= '0;
            mul_done_valid <= 1'b0;
            out_valid      <= 1'b0;
            mul_start      <= 1'b0;
            out_alu_op     <= '0;
            out_set_nop    <= 1'b0;
            out_illegal    <= 1'b0;
            out_is_branch  <= 1'b0;
            out_rd         <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            pend_rd        <= pend_rd_nxt;
            mul_done_valid <= done_nxt;
            out_valid      <= accept;
            mul_start      <= accept & dec_mul;
            if (accept) begin
                out_alu_op    <= dec_op;
                out_set_nop   <= dec_nop;
                out_illegal   <= dec_ill;
                out_is_branch <= dec_br;
                out_rd        <= in_rd;
            end
        end
    end

    assign mul_done_rd = pend_rd;
    assign busy        = (state == MUL_WAIT);

endmodule

// File: tb/tb_alu_issue_control.sv
module tb_alu_issue_control;

    localparam int NI = 2;

    typedef struct {
        logic [1:0] op;
        logic       nop, ill, br, mul;
        logic [4:0] rd;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [4:0] rd;
        int         cyc;
    } done_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid [NI];
    logic       in_ready [NI];
    logic [6:0] in_funct7 [NI];
    logic [2:0] in_funct3 [NI];
    logic [1:0] in_cu [NI];
    logic [4:0] in_rd [NI];
    logic       out_valid [NI];
    logic [1:0] out_alu_op [NI];
    logic       out_set_nop [NI];
    logic       out_illegal [NI];
    logic       out_is_branch [NI];
    logic [4:0] out_rd [NI];
    logic       mul_start [NI];
    logic       mul_done_valid [NI];
    logic [4:0] mul_done_rd [NI];
    logic       busy [NI];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    exp_t  oq [NI][$];
    done_t dq [NI][$];

    int         done_cyc [NI];
    logic [4:0] pend_rd [NI];
    int         cur_kind [NI];
    logic       cur_valid [NI];
    logic       need_new [NI];
    int         dir_idx [NI];

    // instance 0: latency 4 with overlap; instance 1: latency 2, full stall
    alu_issue_control #(.MUL_LATENCY(4), .RD_WIDTH(5), .OVERLAP(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_funct7(in_funct7[0]), .in_funct3(in_funct3[0]),
        .in_cu_alu_op(in_cu[0]), .in_rd(in_rd[0]),
        .out_valid(out_valid[0]), .out_alu_op(out_alu_op[0]),
        .out_set_nop(out_set_nop[0]), .out_illegal(out_illegal[0]),
        .out_is_branch(out_is_branch[0]), .out_rd(out_rd[0]),
        .mul_start(mul_start[0]), .mul_done_valid(mul_done_valid[0]),
        .mul_done_rd(mul_done_rd[0]), .busy(busy[0]));

    alu_issue_control #(.MUL_LATENCY(2), .RD_WIDTH(5), .OVERLAP(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_funct7(in_funct7[1]), .in_funct3(in_funct3[1]),
        .in_cu_alu_op(in_cu[1]), .in_rd(in_rd[1]),
        .out_valid(out_valid[1]), .out_alu_op(out_alu_op[1]),
        .out_set_nop(out_set_nop[1]), .out_illegal(out_illegal[1]),
        .out_is_branch(out_is_branch[1]), .out_rd(out_rd[1]),
        .mul_start(mul_start[1]), .mul_done_valid(mul_done_valid[1]),
        .mul_done_rd(mul_done_rd[1]), .busy(busy[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // op kinds: 0 add, 1 sub, 2 mul, 3 illegal R-type, 4 I/S-type, 5 branch, 6 jump
    localparam int DIR_N = 8;
    int         dir_kind [DIR_N] = '{0, 2, 2, 1, 0, 3, 5, 6};
    logic [4:0] dir_rd   [DIR_N] = '{5'd3, 5'd5, 5'd6, 5'd7, 5'd5, 5'd2, 5'd0, 5'd1};

    function automatic int lat(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic bit model_busy(input int i);
        return (cyc >= done_cyc[i] - lat(i)) && (cyc < done_cyc[i]);
    endfunction

    function automatic bit model_ready(input int i, input int kind, input logic [4:0] rd);
        if (!model_busy(i)) return 1'b1;
        if (i == 1) return 1'b0;
        if (kind == 2) return 1'b0;
        if (rd != 5'd0 && rd == pend_rd[i]) return 1'b0;
        if (done_cyc[i] - cyc == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, i, cyc, act, exp);
        end
    endtask

    task automatic encode(input int i, input int kind);
        in_funct7[i] = 7'($urandom);
        in_funct3[i] = 3'($urandom);
        case (kind)
            0: begin in_cu[i] = 2'b10; in_funct7[i] = 7'b0000000; in_funct3[i] = 3'b000; end
            1: begin in_cu[i] = 2'b10; in_funct7[i] = 7'b0100000; in_funct3[i] = 3'b000; end
            2: begin in_cu[i] = 2'b10; in_funct7[i] = 7'b0000001; in_funct3[i] = 3'b000; end
            3: begin
                in_cu[i] = 2'b10;
                if ($urandom_range(1, 0) == 0) begin
                    in_funct7[i] = 7'b0100001; in_funct3[i] = 3'b000;
                end else begin
                    in_funct7[i] = 7'b0000000; in_funct3[i] = 3'($urandom_range(7, 1));
                end
            end
            4: in_cu[i] = 2'b00;
            5: in_cu[i] = 2'b01;
            default: in_cu[i] = 2'b11;
        endcase
    endtask

    task automatic check_reset_zero(input int i);
        chk("rst_in_ready", i, int'(in_ready[i]), 0);
        chk("rst_out_valid", i, int'(out_valid[i]), 0);
        chk("rst_alu_op", i, int'(out_alu_op[i]), 0);
        chk("rst_set_nop", i, int'(out_set_nop[i]), 0);
        chk("rst_illegal", i, int'(out_illegal[i]), 0);
        chk("rst_is_branch", i, int'(out_is_branch[i]), 0);
        chk("rst_out_rd", i, int'(out_rd[i]), 0);
        chk("rst_mul_start", i, int'(mul_start[i]), 0);
        chk("rst_mul_done", i, int'(mul_done_valid[i]), 0);
        chk("rst_mul_done_rd", i, int'(mul_done_rd[i]), 0);
        chk("rst_busy", i, int'(busy[i]), 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NI; i++) begin
            oq[i].delete();
            dq[i].delete();
            done_cyc[i]  = 0;
            pend_rd[i]   = 5'd0;
            cur_valid[i] = 1'b0;
            need_new[i]  = 1'b1;
            in_valid[i]  = 1'b0;
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (out_valid[i]) begin
                if (oq[i].size() == 0) begin
                    chk("unexpected_out_valid", i, 1, 0);
                end else begin
                    exp_t e;
                    e = oq[i].pop_front();
                    chk("out_cycle", i, cyc, e.cyc);
                    chk("out_alu_op", i, int'(out_alu_op[i]), int'(e.op));
                    chk("out_set_nop", i, int'(out_set_nop[i]), int'(e.nop));
                    chk("out_illegal", i, int'(out_illegal[i]), int'(e.ill));
                    chk("out_is_branch", i, int'(out_is_branch[i]), int'(e.br));
                    chk("out_rd", i, int'(out_rd[i]), int'(e.rd));
                    chk("mul_start", i, int'(mul_start[i]), int'(e.mul));
                end
            end else if (mul_start[i]) begin
                chk("mul_start_without_out", i, 1, 0);
            end
            if (mul_done_valid[i]) begin
                if (dq[i].size() == 0) begin
                    chk("unexpected_mul_done", i, 1, 0);
                end else begin
                    done_t d;
                    d = dq[i].pop_front();
                    chk("mul_done_cycle", i, cyc, d.cyc);
                    chk("mul_done_rd", i, int'(mul_done_rd[i]), int'(d.rd));
                end
            end
        end
    end

    // Driver plus reference model
    task automatic run_cycles(input int n, input bit allow_rst, input bit idle_only);
        bit did_rst = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (allow_rst && !did_rst && k >= 150 && model_busy(0) && done_cyc[0] - cyc == 2) begin
                did_rst = 1'b1;
                #1 rst_n = 1'b0;
                #1;
                for (int i = 0; i < NI; i++) check_reset_zero(i);
                clear_model();
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            for (int i = 0; i < NI; i++) begin
                if (need_new[i]) begin
                    if (idle_only) begin
                        cur_valid[i] = 1'b0;
                    end else if (dir_idx[i] < DIR_N) begin
                        cur_valid[i] = 1'b1;
                        cur_kind[i]  = dir_kind[dir_idx[i]];
                        in_rd[i]     = dir_rd[dir_idx[i]];
                        dir_idx[i]++;
                    end else begin
                        cur_valid[i] = ($urandom_range(9, 0) < 7);
                        cur_kind[i]  = int'($urandom_range(6, 0));
                        in_rd[i]     = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(7, 1));
                    end
                    encode(i, cur_kind[i]);
                    in_valid[i] = cur_valid[i];
                end
            end
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                bit rdy;
                rdy = model_ready(i, cur_kind[i], in_rd[i]);
                chk("in_ready", i, int'(in_ready[i]), int'(rdy));
                chk("busy", i, int'(busy[i]), int'(model_busy(i)));
                if (cur_valid[i] && rdy) begin
                    exp_t e;
                    e.op  = (cur_kind[i] == 1 || cur_kind[i] == 5) ? 2'b01 :
                            (cur_kind[i] == 2) ? 2'b10 : 2'b00;
                    e.nop = (cur_kind[i] == 3 || cur_kind[i] == 6);
                    e.ill = (cur_kind[i] == 3);
                    e.br  = (cur_kind[i] == 5);
                    e.mul = (cur_kind[i] == 2);
                    e.rd  = in_rd[i];
                    e.cyc = cyc + 1;
                    oq[i].push_back(e);
                    if (e.mul) begin
                        done_t d;
                        d.rd  = in_rd[i];
                        d.cyc = cyc + 1 + lat(i);
                        dq[i].push_back(d);
                        done_cyc[i] = d.cyc;
                        pend_rd[i]  = in_rd[i];
                    end
                    need_new[i] = 1'b1;
                end else begin
                    need_new[i] = !cur_valid[i];
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            in_funct7[i] = 7'd0;
            in_funct3[i] = 3'd0;
            in_cu[i]     = 2'd0;
            in_rd[i]     = 5'd0;
            dir_idx[i]   = 0;
            cur_kind[i]  = 0;
        end
        clear_model();
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_reset_zero(i);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_cycles(600, 1'b1, 1'b0);
        run_cycles(30, 1'b0, 1'b1);
        for (int i = 0; i < NI; i++) begin
            chk("out_queue_drained", i, oq[i].size(), 0);
            chk("done_queue_drained", i, dq[i].size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
